// File: rtl/mem_access_unit.sv
// Load/store sequencer between the multicycle CPU control path and a
// word-wide data memory. Byte/halfword stores become read-modify-write,
// byte/halfword loads are lane-selected and zero/sign-extended.
//
// Handshake: req is sampled only while idle (busy=0). Once accepted, the
// request fields are latched and may change freely; busy stays high up to
// and including the single cycle in which done pulses. rdata/err are valid
// while done=1 and hold until the next accepted request. Requests seen while
// busy (including the done cycle) are dropped, not queued.
//
// All memory-side controls (rena, wena, addr, wdata) come straight from
// flops so the level-sensitive write enable never glitches.
module mem_access_unit #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              dmem_rena,
  output logic              dmem_wena,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state;
  state_t state_nxt;

  // Request fields captured at acceptance.
  logic        lat_store;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_lo;
  logic [15:0] lat_wdata;

  // Decode of the incoming request (only meaningful in IDLE with req=1).
  logic acc_bad;
  logic acc_needs_read;

  // Lane selection on the word returned by memory during RD.
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  // Address bits above the memory depth alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Classify the request: illegal size/alignment, or whether a read is needed.
  always_comb begin
    acc_bad = 1'b0;
    if (size == 2'b11) begin
      acc_bad = 1'b1;
    end else if ((size == SZ_HALF) && addr[0]) begin
      acc_bad = 1'b1;
    end else if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) begin
      acc_bad = 1'b1;
    end
    acc_needs_read = !is_store || (size != SZ_WORD);
  end

  // Extract the addressed lane for loads and build the merged word for RMW.
  always_comb begin
    byte_sel = dmem_rdata[{lat_lo, 3'b000} +: 8];
    half_sel = dmem_rdata[{lat_lo[1], 4'b0000} +: 16];
    case (lat_size)
      SZ_BYTE: load_val = {{(DATA_W-8){~lat_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{(DATA_W-16){~lat_unsigned & half_sel[15]}}, half_sel};
      default: load_val = dmem_rdata;
    endcase
    merged = dmem_rdata;
    if (lat_size == SZ_BYTE) begin
      merged[{lat_lo, 3'b000} +: 8] = lat_wdata[7:0];
    end else begin
      merged[{lat_lo[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (acc_bad) begin
            state_nxt = ST_DONE;
          end else if (acc_needs_read) begin
            state_nxt = ST_RD;
          end else begin
            state_nxt = ST_WR;
          end
        end
      end
      ST_RD:   state_nxt = lat_store ? ST_WR : ST_DONE;
      ST_WR:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, request latches and memory controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      err          <= 1'b0;
      dmem_rena    <= 1'b0;
      dmem_wena    <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      lat_store    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_lo       <= 2'b00;
      lat_wdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            busy         <= 1'b1;
            dmem_addr    <= addr[ADDR_W+1:2];
            rdata        <= '0;
            err          <= acc_bad;
            lat_store    <= is_store;
            lat_size     <= size;
            lat_unsigned <= is_unsigned;
            lat_lo       <= addr[1:0];
            lat_wdata    <= wdata[15:0];
            if (acc_bad) begin
              done <= 1'b1;
            end else if (acc_needs_read) begin
              dmem_rena <= 1'b1;
            end else begin
              dmem_wdata <= wdata;
              dmem_wena  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          dmem_rena <= 1'b0;
          if (lat_store) begin
            dmem_wdata <= merged;
            dmem_wena  <= 1'b1;
          end else begin
            rdata <= load_val;
            done  <= 1'b1;
          end
        end
        ST_WR: begin
          dmem_wena <= 1'b0;
          done      <= 1'b1;
        end
        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
